// File: rtl/cart_bus_pkg.sv
// rtl/cart_bus_pkg.sv - shared types and constants for the cartridge bus controller
package cart_bus_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    HOLD   = 2'd3
  } state_t;

  localparam int unsigned DEF_SETUP_CYC  = 1;
  localparam int unsigned DEF_ACCESS_CYC = 2;
  localparam int unsigned DEF_HOLD_CYC   = 1;

  // Upper three address bits selecting the cartridge RAM window 0xA000-0xBFFF
  localparam logic [2:0] CART_RAM_BASE_HI = 3'b101;

  function automatic logic is_cart_ram(input logic [15:0] addr);
    return addr[15:13] == CART_RAM_BASE_HI;
  endfunction

endpackage

// File: rtl/cart_bus_ctrl.sv
// rtl/cart_bus_ctrl.sv - timed cartridge bus responder for the rom_rd/rom_bsy handshake (optional CART_WRITE_EN)
module cart_bus_ctrl
  import cart_bus_pkg::*;
#(
  parameter int unsigned SETUP_CYC  = DEF_SETUP_CYC,
  parameter int unsigned ACCESS_CYC = DEF_ACCESS_CYC,
  parameter int unsigned HOLD_CYC   = DEF_HOLD_CYC
) (
  input  logic        clk_8m,
  input  logic        rst_n,
  input  logic [15:0] rom_addr,
  input  logic        rom_rd,
`ifdef CART_WRITE_EN
  input  logic        rom_wr,
  input  logic [7:0]  rom_wdata,
  output logic [7:0]  cart_d_out,
  output logic        cart_d_oe,
`endif
  output logic        rom_bsy,
  output logic [7:0]  rom_data,
  output logic [15:0] cart_a,
  input  logic [7:0]  cart_d_in,
  output logic        cart_rd_n,
  output logic        cart_wr_n,
  output logic        cart_cs_n
);

  localparam logic [3:0] SETUP_LD  = 4'(SETUP_CYC);
  localparam logic [3:0] ACCESS_LD = 4'(ACCESS_CYC);
  localparam logic [3:0] HOLD_LD   = 4'(HOLD_CYC);

  state_t     state, state_nxt;
  logic [3:0] timer, timer_nxt;
  logic       expire;
  logic       start;

`ifdef CART_WRITE_EN
  logic is_wr;
  assign start = rom_rd | rom_wr;
`else
  assign start = rom_rd;
  assign cart_wr_n = 1'b1;
`endif

  // Busy must already be high in the strobe cycle so a requester never sees a stale low
  assign rom_bsy = start | (state != IDLE);

  // State register and per-state down-counter
  always_ff @(posedge clk_8m or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      timer <= 4'd0;
    end else begin
      state <= state_nxt;
      timer <= timer_nxt;
    end
  end

  // Next-state sequencing: each timed state lasts the number of cycles loaded on entry
  always_comb begin
    state_nxt = state;
    timer_nxt = timer;
    expire    = (timer <= 4'd1);
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = SETUP;
          timer_nxt = SETUP_LD;
        end
      end
      SETUP: begin
        if (expire) begin
          state_nxt = ACCESS;
          timer_nxt = ACCESS_LD;
        end else begin
          timer_nxt = timer - 4'd1;
        end
      end
      ACCESS: begin
        if (expire) begin
          state_nxt = HOLD;
          timer_nxt = HOLD_LD;
        end else begin
          timer_nxt = timer - 4'd1;
        end
      end
      HOLD: begin
        if (expire) begin
          state_nxt = IDLE;
          timer_nxt = 4'd0;
        end else begin
          timer_nxt = timer - 4'd1;
        end
      end
      default: begin
        state_nxt = IDLE;
        timer_nxt = 4'd0;
      end
    endcase
  end

  // Registered cart pins and return data; address and /CS held between accesses
  always_ff @(posedge clk_8m or negedge rst_n) begin
    if (!rst_n) begin
      cart_a    <= 16'h0000;
      cart_cs_n <= 1'b1;
      cart_rd_n <= 1'b1;
      rom_data  <= 8'h00;
`ifdef CART_WRITE_EN
      cart_wr_n  <= 1'b1;
      cart_d_out <= 8'h00;
      cart_d_oe  <= 1'b0;
      is_wr      <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            cart_a    <= rom_addr;
            cart_cs_n <= ~is_cart_ram(rom_addr);
`ifdef CART_WRITE_EN
            // A simultaneous read wins; the write is dropped
            is_wr     <= ~rom_rd;
            cart_d_oe <= ~rom_rd;
            if (!rom_rd) begin
              cart_d_out <= rom_wdata;
            end
`endif
          end
        end
        SETUP: begin
          if (expire) begin
`ifdef CART_WRITE_EN
            if (is_wr) begin
              cart_wr_n <= 1'b0;
            end else begin
              cart_rd_n <= 1'b0;
            end
`else
            cart_rd_n <= 1'b0;
`endif
          end
        end
        ACCESS: begin
          if (expire) begin
            cart_rd_n <= 1'b1;
`ifdef CART_WRITE_EN
            cart_wr_n <= 1'b1;
            if (!is_wr) begin
              rom_data <= cart_d_in;
            end
`else
            rom_data <= cart_d_in;
`endif
          end
        end
        HOLD: begin
          if (expire) begin
            cart_cs_n <= 1'b1;
`ifdef CART_WRITE_EN
            cart_d_oe <= 1'b0;
`endif
          end
        end
        default: begin
          cart_rd_n <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cart_bus_ctrl.sv
// tb/tb_cart_bus_ctrl.sv - randomized self-checking bench for cart_bus_ctrl (optional CART_WRITE_EN)
`timescale 1ns/1ps
module tb_cart_bus_ctrl;

  localparam int S_CYC = 1;
  localparam int A_CYC = 2;
  localparam int H_CYC = 1;
  localparam int BUSY_LEN = 1 + S_CYC + A_CYC + H_CYC;

  logic        clk_8m = 1'b0;
  logic        rst_n  = 1'b0;
  logic [15:0] rom_addr = 16'h0000;
  logic        rom_rd = 1'b0;
  logic        rom_bsy;
  logic [7:0]  rom_data;
  logic [15:0] cart_a;
  logic [7:0]  cart_d_in;
  logic        cart_rd_n;
  logic        cart_wr_n;
  logic        cart_cs_n;
`ifdef CART_WRITE_EN
  logic        rom_wr = 1'b0;
  logic [7:0]  rom_wdata = 8'h00;
  logic [7:0]  cart_d_out;
  logic        cart_d_oe;
`endif

  logic [7:0] mem [0:65535];
  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk_8m = ~clk_8m;

  // Cartridge model: drives the addressed byte only while /RD is low
  assign cart_d_in = cart_rd_n ? 8'hFF : mem[cart_a];

  cart_bus_ctrl #(.SETUP_CYC(S_CYC), .ACCESS_CYC(A_CYC), .HOLD_CYC(H_CYC)) dut (
    .clk_8m    (clk_8m),
    .rst_n     (rst_n),
    .rom_addr  (rom_addr),
    .rom_rd    (rom_rd),
`ifdef CART_WRITE_EN
    .rom_wr    (rom_wr),
    .rom_wdata (rom_wdata),
    .cart_d_out(cart_d_out),
    .cart_d_oe (cart_d_oe),
`endif
    .rom_bsy   (rom_bsy),
    .rom_data  (rom_data),
    .cart_a    (cart_a),
    .cart_d_in (cart_d_in),
    .cart_rd_n (cart_rd_n),
    .cart_wr_n (cart_wr_n),
    .cart_cs_n (cart_cs_n)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Issue one read at the current negedge and follow it until busy drops.
  // glitch_at: cycle index at which a stray strobe is injected (0 = none).
  task automatic do_read(input logic [15:0] addr, input int glitch_at);
    int busy_n, rd_low_n, rd_first, cs_low_n;
    logic done, in_ram;
    logic [7:0] exp_data;
    exp_data = mem[addr];
    in_ram = (addr >= 16'hA000) && (addr <= 16'hBFFF);
    rom_rd = 1'b1;
    rom_addr = addr;
    #1;
    check("bsy_in_strobe", rom_bsy, 1);
    busy_n = 1; rd_low_n = 0; rd_first = -1; cs_low_n = 0; done = 1'b0;
    for (int i = 1; i <= 40 && !done; i++) begin
      @(negedge clk_8m);
      rom_rd = (i == glitch_at);
      rom_addr = 16'($urandom);
      #1;
      if (!rom_bsy) begin
        done = 1'b1;
      end else begin
        busy_n++;
        if (!cart_rd_n) begin
          rd_low_n++;
          if (rd_first < 0) rd_first = i;
        end
        if (!cart_cs_n) cs_low_n++;
      end
    end
    check("read_completed", done, 1);
    check("busy_cycles", busy_n, BUSY_LEN);
    check("rd_low_cycles", rd_low_n, A_CYC);
    check("rd_first_cycle", rd_first, 1 + S_CYC);
    check("cs_low_cycles", cs_low_n, in_ram ? (S_CYC + A_CYC + H_CYC) : 0);
    check("rom_data", rom_data, exp_data);
    check("cart_a_held", cart_a, addr);
    check("cs_idle_high", cart_cs_n, 1);
  endtask

  task automatic idle_check(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk_8m);
      rom_addr = 16'($urandom);
      #1;
      check("idle_bsy_low", rom_bsy, 0);
      check("idle_rd_high", cart_rd_n, 1);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] a;
    logic [7:0]  held;
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    mem[16'h0104] = 8'hCE;

    // Reset state
    #12;
    check("rst_rd_n", cart_rd_n, 1);
    check("rst_wr_n", cart_wr_n, 1);
    check("rst_cs_n", cart_cs_n, 1);
    check("rst_cart_a", cart_a, 0);
    check("rst_rom_data", rom_data, 0);
    check("rst_bsy", rom_bsy, 0);
    @(negedge clk_8m);
    rst_n = 1'b1;
    @(negedge clk_8m);

    // Directed reads: ROM byte and cart RAM chip select
    do_read(16'h0104, 0);
    check("rom_data_ce", rom_data, 8'hCE);
    do_read(16'hA010, 0);

    // Back-to-back reads, each strobe in the first idle cycle
    for (int k = 0; k < 48; k++) do_read(16'h0104 + 16'(k), 0);

    // Stray strobe during ACCESS is ignored
    do_read(16'h0150, 1 + S_CYC);
    held = rom_data;
    idle_check(3);
    check("glitch_data_kept", rom_data, held);

    // Reset during ACCESS aborts at once
    do_read(16'h0104, 0);
    rom_rd = 1'b1; rom_addr = 16'h0200;
    @(negedge clk_8m); rom_rd = 1'b0;
    @(negedge clk_8m);
    #1;
    check("pre_reset_in_access", cart_rd_n, 0);
    rst_n = 1'b0;
    #1;
    check("abort_rd_n", cart_rd_n, 1);
    check("abort_bsy", rom_bsy, 0);
    check("abort_rom_data", rom_data, 0);
    check("abort_cs_n", cart_cs_n, 1);
    @(negedge clk_8m);
    rst_n = 1'b1;
    @(negedge clk_8m);
    do_read(16'h0200, 0);

    // Randomized reads with random gaps, RAM-window bias and stray strobes
    for (int k = 0; k < 40; k++) begin
      a = 16'($urandom);
      if ($urandom_range(0, 2) == 0) a[15:13] = 3'b101;
      for (int g = $urandom_range(0, 3); g > 0; g--) begin
        @(negedge clk_8m);
        rom_addr = 16'($urandom);
      end
      do_read(a, $urandom_range(0, 1 + S_CYC + A_CYC));
    end

`ifdef CART_WRITE_EN
    begin
      int wr_low_n, rd_low_n, oe_n;
      logic done;
      held = rom_data;
      @(negedge clk_8m);
      rom_wr = 1'b1; rom_wdata = 8'h01; rom_addr = 16'h2000;
      #1;
      check("wr_bsy_strobe", rom_bsy, 1);
      wr_low_n = 0; rd_low_n = 0; oe_n = 0; done = 1'b0;
      for (int i = 1; i <= 40 && !done; i++) begin
        @(negedge clk_8m);
        rom_wr = 1'b0; rom_wdata = 8'($urandom);
        #1;
        if (!rom_bsy) done = 1'b1;
        if (!cart_wr_n) wr_low_n++;
        if (!cart_rd_n) rd_low_n++;
        if (cart_d_oe && cart_d_out == 8'h01) oe_n++;
      end
      check("wr_done", done, 1);
      check("wr_low_cycles", wr_low_n, A_CYC);
      check("wr_rd_stays_high", rd_low_n, 0);
      check("wr_oe_cycles", oe_n, S_CYC + A_CYC + H_CYC);
      check("wr_rom_data_kept", rom_data, held);
      check("wr_cart_a", cart_a, 16'h2000);
      rom_wr = 1'b1;
      do_read(16'h0104, 0);
      rom_wr = 1'b0;
      check("rd_wins_over_wr", rom_data, 8'hCE);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
